// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier with per-operation signed/unsigned mode.
// Each operation takes WIDTH/2+1 Booth steps, one per clock, and is framed by
// valid/ready handshakes on the operand side and on the product side.
module booth_seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] P,
   output logic               busy
);

   // Operands are carried as WIDTH+2 bits so that unsigned values become
   // non-negative two's complement numbers and the triplet count is integral.
   localparam int EW = WIDTH + 2;
   // Upper accumulator half: one bit for the 2A partial product, one guard bit.
   localparam int HW = EW + 2;
   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [EW-1:0]   mcand;     // extended multiplicand
   logic [HW-1:0]   acc_hi;    // running partial sum
   logic [EW-1:0]   acc_lo;    // multiplier bits, shifted out two per step
   logic            q_m1;      // b[2i-1] of the current triplet
   logic [CW-1:0]   cnt;

   logic [EW-1:0]   a_ext;
   logic [EW-1:0]   b_ext;
   logic [HW-1:0]   m_one;
   logic [HW-1:0]   m_two;
   logic [HW-1:0]   pp;
   logic [HW-1:0]   sum;
   logic [HW+EW-1:0] shifted;
   logic            accept;
   logic            last_step;

   assign a_ext = signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
   assign b_ext = signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

   assign m_one = {{2{mcand[EW-1]}}, mcand};
   assign m_two = {m_one[HW-2:0], 1'b0};

   // Booth partial-product selection from the current multiplier triplet.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      pp = '0;
      unique case ({acc_lo[1:0], q_m1})
         3'b001, 3'b010: pp = m_one;
         3'b011:         pp = m_two;
         3'b100:         pp = -m_two;
         3'b101, 3'b110: pp = -m_one;
         default:        pp = '0;
      endcase
   end

   // Add into the upper half, then arithmetic shift the whole accumulator by 2.
   assign sum     = acc_hi + pp;
   assign shifted = {{2{sum[HW-1]}}, sum, acc_lo[EW-1:2]};

   assign accept    = (state == IDLE) && in_valid;
   assign last_step = (cnt == CW'(1));

   assign in_ready  = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

   // State register; reset has priority over any handshake.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (in_valid)  state_next = CALC;
         CALC:    if (last_step) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand capture, Booth steps, product register.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         q_m1   <= 1'b0;
         cnt    <= '0;
         P      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= a_ext;
                  acc_lo <= b_ext;
                  acc_hi <= '0;
                  q_m1   <= 1'b0;
                  cnt    <= CW'(N);
               end
            end
            CALC: begin
               acc_hi <= shifted[HW+EW-1:EW];
               acc_lo <= shifted[EW-1:0];
               q_m1   <= acc_lo[1];
               cnt    <= cnt - CW'(1);
               if (last_step) P <= shifted[2*WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier (WIDTH = 32): the driver pushes
// expected products into a scoreboard queue, a monitor pops and compares.
module tb_booth_seq_multiplier;

   localparam int W = 32;
   localparam int N = W / 2 + 1;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic            signed_mode;
   logic [W-1:0]    A;
   logic [W-1:0]    B;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  P;
   logic            busy;

   booth_seq_multiplier #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .signed_mode (signed_mode),
      .A           (A),
      .B           (B),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .P           (P),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] p;
      int          edge_no;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 2;   // 0 random, 1 hold low, 2 hold high
   bit   seen = 0;
   int   last_accept = 0;

   // Reference: the exact product of the operands as plain integers.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic sm);
      longint      sa;
      longint      sb;
      logic [63:0] ua;
      logic [63:0] ub;
      if (sm) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", {63'b0, out_valid}, 64'd0);
            end else begin
               if (!seen) begin
                  seen = 1;
                  check("latency", 64'(cyc - exp_q[0].edge_no), 64'(N));
               end
               check("product", P, exp_q[0].p);
               check("in_ready_done", {63'b0, in_ready}, 64'd0);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  seen = 0;
               end
            end
         end else if (exp_q.size() != 0) begin
            check("busy_calc", {63'b0, busy}, 64'd1);
            check("in_ready_calc", {63'b0, in_ready}, 64'd0);
         end
      end
   end

   // Consumer-side ready driver.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = ($urandom_range(0, 3) != 0);
         1:       out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   end

   // Offer one operation, push its expected product at the accept edge.
   // With noise set, inputs are scrambled every cycle while the op is in CALC.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sm,
                        input logic [63:0] expect_p, input bit noise);
      int waitc;
      int acc_edge;
      waitc = 0;
      @(posedge clk);
      #1;
      A = a;
      B = b;
      signed_mode = sm;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waitc++;
         if (waitc > 200) begin
            check("accept_timeout", {63'b0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
         end
      end
      acc_edge = cyc + 1;
      @(posedge clk);
      #1;
      exp_q.push_back('{p: expect_p, edge_no: acc_edge});
      last_accept = acc_edge;
      in_valid = 1'b0;
      if (noise) begin
         repeat (N) begin
            A = $urandom;
            B = $urandom;
            signed_mode = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int waitc;
      waitc = 0;
      while (exp_q.size() != 0 && waitc < 500) begin
         @(negedge clk);
         waitc++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         seen = 0;
      end
   endtask

   logic [31:0] ra;
   logic [31:0] rb;
   logic        rs;
   int          prev_accept;
   logic [31:0] corners [5];

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      A = '0;
      B = '0;
      signed_mode = 1'b0;
      out_ready = 1'b1;
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'h7FFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'hFFFF_FFFF;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in_ready_in_reset", {63'b0, in_ready}, 64'd0);
      check("p_reset", P, 64'd0);
      check("out_valid_reset", {63'b0, out_valid}, 64'd0);
      check("busy_reset", {63'b0, busy}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", {63'b0, in_ready}, 64'd1);

      // Directed products.
      issue(32'hFFFF_FFF9, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
      wait_idle();
      issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
      issue(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 1'b0);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
      wait_idle();

      // Throughput with out_ready tied high.
      issue(32'd12345, 32'd678, 1'b0, model(32'd12345, 32'd678, 1'b0), 1'b0);
      prev_accept = last_accept;
      issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, model(32'hDEAD_BEEF, 32'h1234_5678, 1'b1), 1'b0);
      check("accept_spacing", 64'(last_accept - prev_accept), 64'(N + 2));
      wait_idle();

      // Backpressure: hold out_ready low, offer new operands meanwhile.
      ready_mode = 1;
      issue(32'h0BAD_F00D, 32'hF00D_CAFE, 1'b1, model(32'h0BAD_F00D, 32'hF00D_CAFE, 1'b1), 1'b0);
      begin
         int waitc;
         waitc = 0;
         while (!out_valid && waitc < 50) begin
            @(negedge clk);
            waitc++;
         end
         check("out_valid_arrives", {63'b0, out_valid}, 64'd1);
      end
      repeat (10) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         A = $urandom;
         B = $urandom;
         @(negedge clk);
         check("out_valid_held", {63'b0, out_valid}, 64'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ready_mode = 2;
      out_ready = 1'b1;
      wait_idle();
      @(negedge clk);
      check("in_ready_after_consume", {63'b0, in_ready}, 64'd1);
      check("busy_after_consume", {63'b0, busy}, 64'd0);

      // Inputs scrambled during CALC must not disturb the captured operands.
      ready_mode = 0;
      repeat (4) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom);
         issue(ra, rb, rs, model(ra, rb, rs), 1'b1);
      end
      wait_idle();

      // Reset in the middle of CALC aborts the operation.
      ready_mode = 2;
      issue(32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 64'd0, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      seen = 0;
      @(negedge clk);
      check("abort_out_valid", {63'b0, out_valid}, 64'd0);
      check("abort_p", P, 64'd0);
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_in_ready", {63'b0, in_ready}, 64'd1);
      issue(32'hFFFF_FFFE, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0);
      wait_idle();

      // Randomized operations with corner-biased operands and random backpressure.
      ready_mode = 0;
      for (int i = 0; i < 300; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
         rs = 1'($urandom);
         issue(ra, rb, rs, model(ra, rb, rs), 1'b0);
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
